dsc_byp_h2c_fifo: RTL and testbench
===================================

// Module: dsc_byp_h2c_fifo
// PURPOSE
// Buffered, parametrised H2C descriptor-bypass loopback between the QDMA byp_out and byp_in ports.
// Decodes each bypassed descriptor into MM or ST fields and queues it in a per-path FIFO.
// Injects marker descriptors on request and tracks each marker until its response returns, with a timeout.
// Counts descriptors dropped while bypass is disabled. Sits in the example top beside the C2H bypass logic.
// PARAMETERS
// FIFO_DEPTH  4      entries per path (MM, ST); power of 2, >=2
// QID_W       11     queue-id width
// TMO_CYC     4096   marker-response timeout in clocks; >=2
// CNT_W       16     drop-counter width
// PORTS
// axi_aclk              in   1      clock
// axi_aresetn           in   1      async reset, active low
// h2c_dsc_bypass        in   1      1 = forward descriptors to byp_in; 0 = drop and count
// h2c_{mm,st}_marker_req in  1      1-cycle marker request pulse, per path
// marker_qid            in   QID_W  qid placed in injected marker descriptors
// h2c_{mm,st}_marker_rsp out 1      1-cycle pulse: marker response received
// h2c_{mm,st}_marker_busy out 1     marker pending or in flight
// h2c_{mm,st}_marker_tmo out 1      1-cycle pulse: no response within TMO_CYC
// drop_cnt              out  CNT_W  saturating count of dropped descriptors
// h2c_byp_out_{dsc[256],fmt[3],st_mm,dsc_sz[2],qid[QID_W],error,func[8],cidx[16],port_id[3],vld}  in
// h2c_byp_out_rdy       out  1      byp_out ready
// h2c_byp_in_mm_{radr[64],wadr[64],len[16],mrkr_req,sdi,qid,error,func,cidx,port_id,no_dma,vld}  out
// h2c_byp_in_mm_rdy     in   1
// h2c_byp_in_st_{addr[64],len[16],eop,sop,mrkr_req,sdi,qid,error,func,cidx,port_id,no_dma,vld}  out
// h2c_byp_in_st_rdy     in   1
// BEHAVIOUR
// Reset: FIFOs empty; all byp_in outputs 0; rsp/busy/tmo 0; drop_cnt 0; both FSMs IDLE.
//   h2c_byp_out_rdy=0 while axi_aresetn is low. Reset mid-transfer discards all queued entries.
// Input acceptance: acc = byp_out_vld & byp_out_rdy.
//   rdy=1 if fmt==3'b001 (marker response, always consumed).
//   Else rdy=1 if bypass=0 (drop).
//   Else rdy = target FIFO (MM if st_mm, else ST) not full AND that path is not injecting a marker this cycle.
// Push/drop: non-marker acc with bypass=1 pushes the decoded entry into the target FIFO.
//   Non-marker acc with bypass=0: drop, drop_cnt++ saturating at all-ones. Other fmt values are treated as normal descriptors.
// MM decode: radr=dsc[63:0], wadr=dsc[191:128], len=dsc[79:64], sdi=dsc[94], mrkr_req=0, no_dma=0.
// ST decode: addr=dsc[127:64], len=dsc[47:32], sop=dsc[48], eop=dsc[49], sdi=dsc[49], mrkr_req=0, no_dma=0.
// qid/error/func/cidx/port_id are copied unchanged on both paths.
// FIFO output: first-word fall-through. vld = !empty; pop on vld&rdy.
//   Latency: accepted at edge N, visible on byp_in at N+1 (empty FIFO). Push and pop in the same cycle are allowed when full.
// Marker FSM (one per path): IDLE -> PEND -> WAIT -> IDLE.
//   IDLE: req pulse -> PEND; busy=1.
//   PEND: if FIFO not full, push marker entry (mrkr_req=1, no_dma=1, len=0, addr=0, sdi=0, qid=marker_qid, other fields 0) -> WAIT.
//     The marker has priority over the input that cycle. Push happens regardless of the h2c_dsc_bypass setting.
//   WAIT: acc with fmt==3'b001 and st_mm matching the path -> rsp pulse next cycle, -> IDLE.
//     Timer reaches TMO_CYC-1 -> tmo pulse next cycle, -> IDLE.
//   Response and timeout in the same cycle: response wins, no tmo.
//   Req while busy: ignored. Response while not in WAIT: consumed, no pulse.
//   A response routes to the path selected by its st_mm, independently of the other path's FSM.
// Toggling h2c_dsc_bypass mid-stream does not flush the FIFOs; queued entries still drain.
// TESTING
// 1. bypass=1, 4 MM dsc (len=0x40, dsc[94]=1 on last), mm_rdy=0 -> 4 accepted, 5th stalls (rdy=0); mm_rdy=1 -> 4 out in order, sdi only on last.
// 2. bypass=1, ST dsc with dsc[48]=1, dsc[49]=1, len=0x100, addr=0x1000 -> st_vld at N+1 with sop=eop=sdi=1, len=0x100, addr=0x1000.
// 3. bypass=0, 10 dsc -> rdy held 1, no byp_in vld, drop_cnt=10. CNT_W=4 with 20 dsc -> drop_cnt=15.
// 4. mm_marker_req pulse, marker_qid=5; response fmt=1, st_mm=1, 20 cycles later -> marker on mm port (mrkr_req=1, no_dma=1, qid=5); mm_marker_rsp single pulse; busy high throughout.
// 5. TMO_CYC=16, st_marker_req, no response -> st_marker_tmo pulses exactly 16 cycles after marker push; busy=0 after.
// 6. axi_aresetn low with 3 entries queued and WAIT active -> all vld/busy=0 immediately, drop_cnt=0, FIFOs empty on release.

Source files
------------

// File: rtl/dsc_byp_h2c_fifo_if.sv
// H2C descriptor-bypass bundle: byp_out descriptor stream from QDMA and the
// MM/ST byp_in streams back into it. master = loopback block, slave = QDMA side.
interface dsc_byp_h2c_fifo_if #(
    parameter int QID_W = 11
);
    logic [255:0]     h2c_byp_out_dsc;
    logic [2:0]       h2c_byp_out_fmt;
    logic             h2c_byp_out_st_mm;
    logic [1:0]       h2c_byp_out_dsc_sz;
    logic [QID_W-1:0] h2c_byp_out_qid;
    logic             h2c_byp_out_error;
    logic [7:0]       h2c_byp_out_func;
    logic [15:0]      h2c_byp_out_cidx;
    logic [2:0]       h2c_byp_out_port_id;
    logic             h2c_byp_out_vld;
    logic             h2c_byp_out_rdy;

    logic [63:0]      h2c_byp_in_mm_radr;
    logic [63:0]      h2c_byp_in_mm_wadr;
    logic [15:0]      h2c_byp_in_mm_len;
    logic             h2c_byp_in_mm_mrkr_req;
    logic             h2c_byp_in_mm_sdi;
    logic [QID_W-1:0] h2c_byp_in_mm_qid;
    logic             h2c_byp_in_mm_error;
    logic [7:0]       h2c_byp_in_mm_func;
    logic [15:0]      h2c_byp_in_mm_cidx;
    logic [2:0]       h2c_byp_in_mm_port_id;
    logic             h2c_byp_in_mm_no_dma;
    logic             h2c_byp_in_mm_vld;
    logic             h2c_byp_in_mm_rdy;

    logic [63:0]      h2c_byp_in_st_addr;
    logic [15:0]      h2c_byp_in_st_len;
    logic             h2c_byp_in_st_eop;
    logic             h2c_byp_in_st_sop;
    logic             h2c_byp_in_st_mrkr_req;
    logic             h2c_byp_in_st_sdi;
    logic [QID_W-1:0] h2c_byp_in_st_qid;
    logic             h2c_byp_in_st_error;
    logic [7:0]       h2c_byp_in_st_func;
    logic [15:0]      h2c_byp_in_st_cidx;
    logic [2:0]       h2c_byp_in_st_port_id;
    logic             h2c_byp_in_st_no_dma;
    logic             h2c_byp_in_st_vld;
    logic             h2c_byp_in_st_rdy;

    modport master (
        input  h2c_byp_out_dsc, h2c_byp_out_fmt, h2c_byp_out_st_mm, h2c_byp_out_dsc_sz,
               h2c_byp_out_qid, h2c_byp_out_error, h2c_byp_out_func, h2c_byp_out_cidx,
               h2c_byp_out_port_id, h2c_byp_out_vld,
        output h2c_byp_out_rdy,
        output h2c_byp_in_mm_radr, h2c_byp_in_mm_wadr, h2c_byp_in_mm_len, h2c_byp_in_mm_mrkr_req,
               h2c_byp_in_mm_sdi, h2c_byp_in_mm_qid, h2c_byp_in_mm_error, h2c_byp_in_mm_func,
               h2c_byp_in_mm_cidx, h2c_byp_in_mm_port_id, h2c_byp_in_mm_no_dma, h2c_byp_in_mm_vld,
        input  h2c_byp_in_mm_rdy,
        output h2c_byp_in_st_addr, h2c_byp_in_st_len, h2c_byp_in_st_eop, h2c_byp_in_st_sop,
               h2c_byp_in_st_mrkr_req, h2c_byp_in_st_sdi, h2c_byp_in_st_qid, h2c_byp_in_st_error,
               h2c_byp_in_st_func, h2c_byp_in_st_cidx, h2c_byp_in_st_port_id, h2c_byp_in_st_no_dma,
               h2c_byp_in_st_vld,
        input  h2c_byp_in_st_rdy
    );

    modport slave (
        output h2c_byp_out_dsc, h2c_byp_out_fmt, h2c_byp_out_st_mm, h2c_byp_out_dsc_sz,
               h2c_byp_out_qid, h2c_byp_out_error, h2c_byp_out_func, h2c_byp_out_cidx,
               h2c_byp_out_port_id, h2c_byp_out_vld,
        input  h2c_byp_out_rdy,
        input  h2c_byp_in_mm_radr, h2c_byp_in_mm_wadr, h2c_byp_in_mm_len, h2c_byp_in_mm_mrkr_req,
               h2c_byp_in_mm_sdi, h2c_byp_in_mm_qid, h2c_byp_in_mm_error, h2c_byp_in_mm_func,
               h2c_byp_in_mm_cidx, h2c_byp_in_mm_port_id, h2c_byp_in_mm_no_dma, h2c_byp_in_mm_vld,
        output h2c_byp_in_mm_rdy,
        input  h2c_byp_in_st_addr, h2c_byp_in_st_len, h2c_byp_in_st_eop, h2c_byp_in_st_sop,
               h2c_byp_in_st_mrkr_req, h2c_byp_in_st_sdi, h2c_byp_in_st_qid, h2c_byp_in_st_error,
               h2c_byp_in_st_func, h2c_byp_in_st_cidx, h2c_byp_in_st_port_id, h2c_byp_in_st_no_dma,
               h2c_byp_in_st_vld,
        output h2c_byp_in_st_rdy
    );
endinterface

// File: rtl/dsc_byp_h2c_fifo.sv
// H2C descriptor-bypass loopback: decodes byp_out descriptors into per-path
// (MM/ST) first-word-fall-through FIFOs, injects/tracks markers, counts drops.
module dsc_byp_h2c_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int QID_W      = 11,
    parameter int TMO_CYC    = 4096,
    parameter int CNT_W      = 16
) (
    input  logic               axi_aclk,
    input  logic               axi_aresetn,
    input  logic               h2c_dsc_bypass,
    input  logic               h2c_mm_marker_req,
    input  logic               h2c_st_marker_req,
    input  logic [QID_W-1:0]   marker_qid,
    output logic               h2c_mm_marker_rsp,
    output logic               h2c_mm_marker_busy,
    output logic               h2c_mm_marker_tmo,
    output logic               h2c_st_marker_rsp,
    output logic               h2c_st_marker_busy,
    output logic               h2c_st_marker_tmo,
    output logic [CNT_W-1:0]   drop_cnt,
    dsc_byp_h2c_fifo_if.master byp
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TMO_CYC);

    typedef enum logic [1:0] {IDLE, PEND, WAIT} mst_e;

    // One entry layout serves both paths; addr is radr on MM, wadr unused on ST.
    typedef struct packed {
        logic [63:0]      addr;
        logic [63:0]      wadr;
        logic [15:0]      len;
        logic             sop;
        logic             eop;
        logic             mrkr_req;
        logic             sdi;
        logic [QID_W-1:0] qid;
        logic             error;
        logic [7:0]       func;
        logic [15:0]      cidx;
        logic [2:0]       port_id;
        logic             no_dma;
    } ent_t;

    function automatic ent_t decode(input logic st_mm, input logic [255:0] d);
        ent_t e;
        e = '0;
        if (st_mm) begin
            e.addr = d[63:0];
            e.wadr = d[191:128];
            e.len  = d[79:64];
            e.sdi  = d[94];
        end else begin
            e.addr = d[127:64];
            e.len  = d[47:32];
            e.sop  = d[48];
            e.eop  = d[49];
            e.sdi  = d[49];
        end
        return e;
    endfunction

    ent_t             mem_q [2][FIFO_DEPTH];
    logic [AW:0]      wptr_q [2];
    logic [AW:0]      rptr_q [2];
    mst_e             state_q [2];
    mst_e             state_d [2];
    logic [TW-1:0]    timer_q [2];
    logic [TW-1:0]    timer_d [2];
    logic [1:0]       rsp_q, rsp_d, tmo_q, tmo_d;
    logic [CNT_W-1:0] drop_q;

    ent_t       head [2];
    ent_t       push_ent [2];
    ent_t       in_ent, mrk_ent;
    logic [1:0] empty, full, pop, space, inj, push, rsp_hit, req;
    logic       is_rsp, tgt, acc, rdy, drop;

    assign req = {h2c_st_marker_req, h2c_mm_marker_req};

    // Path index 0 is MM, 1 is ST.
    always_comb begin
        in_ent          = decode(byp.h2c_byp_out_st_mm, byp.h2c_byp_out_dsc);
        in_ent.qid      = byp.h2c_byp_out_qid;
        in_ent.error    = byp.h2c_byp_out_error;
        in_ent.func     = byp.h2c_byp_out_func;
        in_ent.cidx     = byp.h2c_byp_out_cidx;
        in_ent.port_id  = byp.h2c_byp_out_port_id;
        mrk_ent          = '0;
        mrk_ent.mrkr_req = 1'b1;
        mrk_ent.no_dma   = 1'b1;
        mrk_ent.qid      = marker_qid;

        is_rsp = (byp.h2c_byp_out_fmt == 3'b001);
        tgt    = ~byp.h2c_byp_out_st_mm;
        pop[0] = 1'b0;
        pop[1] = 1'b0;
        for (int p = 0; p < 2; p++) begin
            empty[p] = (wptr_q[p] == rptr_q[p]);
            full[p]  = (wptr_q[p][AW] != rptr_q[p][AW]) &&
                       (wptr_q[p][AW-1:0] == rptr_q[p][AW-1:0]);
            head[p]  = empty[p] ? '0 : mem_q[p][rptr_q[p][AW-1:0]];
        end
        pop[0] = ~empty[0] & byp.h2c_byp_in_mm_rdy;
        pop[1] = ~empty[1] & byp.h2c_byp_in_st_rdy;
        for (int p = 0; p < 2; p++) begin
            space[p] = ~full[p] | pop[p];
            inj[p]   = (state_q[p] == PEND) & space[p];
        end

        // A path with a pending marker refuses input until the marker is in.
        rdy = 1'b0;
        if (!axi_aresetn)         rdy = 1'b0;
        else if (is_rsp)          rdy = 1'b1;
        else if (!h2c_dsc_bypass) rdy = 1'b1;
        else                      rdy = space[tgt] & (state_q[tgt] != PEND);

        acc  = byp.h2c_byp_out_vld & rdy;
        drop = acc & ~is_rsp & ~h2c_dsc_bypass;
        for (int p = 0; p < 2; p++) begin
            push[p]     = inj[p] | (acc & ~is_rsp & h2c_dsc_bypass & (tgt == p[0]));
            push_ent[p] = inj[p] ? mrk_ent : in_ent;
            rsp_hit[p]  = acc & is_rsp & (tgt == p[0]);
        end
    end

    always_ff @(posedge axi_aclk) begin
        for (int p = 0; p < 2; p++) begin
            if (push[p]) mem_q[p][wptr_q[p][AW-1:0]] <= push_ent[p];
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            for (int p = 0; p < 2; p++) begin
                wptr_q[p] <= '0;
                rptr_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (push[p]) wptr_q[p] <= wptr_q[p] + 1'b1;
                if (pop[p])  rptr_q[p] <= rptr_q[p] + 1'b1;
            end
        end
    end

    // Marker FSMs: a response beats a timeout landing in the same cycle.
    always_comb begin
        rsp_d = '0;
        tmo_d = '0;
        for (int p = 0; p < 2; p++) begin
            state_d[p] = state_q[p];
            timer_d[p] = timer_q[p];
            case (state_q[p])
                IDLE: if (req[p]) state_d[p] = PEND;
                PEND: if (space[p]) begin
                    state_d[p] = WAIT;
                    timer_d[p] = '0;
                end
                WAIT: begin
                    if (rsp_hit[p]) begin
                        rsp_d[p]   = 1'b1;
                        state_d[p] = IDLE;
                    end else if (timer_q[p] == TW'(TMO_CYC - 1)) begin
                        tmo_d[p]   = 1'b1;
                        state_d[p] = IDLE;
                    end else begin
                        timer_d[p] = timer_q[p] + 1'b1;
                    end
                end
                default: state_d[p] = IDLE;
            endcase
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            for (int p = 0; p < 2; p++) begin
                state_q[p] <= IDLE;
                timer_q[p] <= '0;
            end
            rsp_q  <= '0;
            tmo_q  <= '0;
            drop_q <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                state_q[p] <= state_d[p];
                timer_q[p] <= timer_d[p];
            end
            rsp_q <= rsp_d;
            tmo_q <= tmo_d;
            if (drop && (drop_q != '1)) drop_q <= drop_q + 1'b1;
        end
    end

    assign h2c_mm_marker_rsp  = rsp_q[0];
    assign h2c_st_marker_rsp  = rsp_q[1];
    assign h2c_mm_marker_tmo  = tmo_q[0];
    assign h2c_st_marker_tmo  = tmo_q[1];
    assign h2c_mm_marker_busy = (state_q[0] != IDLE);
    assign h2c_st_marker_busy = (state_q[1] != IDLE);
    assign drop_cnt           = drop_q;
    assign byp.h2c_byp_out_rdy = rdy;

    assign byp.h2c_byp_in_mm_vld      = ~empty[0];
    assign byp.h2c_byp_in_mm_radr     = head[0].addr;
    assign byp.h2c_byp_in_mm_wadr     = head[0].wadr;
    assign byp.h2c_byp_in_mm_len      = head[0].len;
    assign byp.h2c_byp_in_mm_mrkr_req = head[0].mrkr_req;
    assign byp.h2c_byp_in_mm_sdi      = head[0].sdi;
    assign byp.h2c_byp_in_mm_qid      = head[0].qid;
    assign byp.h2c_byp_in_mm_error    = head[0].error;
    assign byp.h2c_byp_in_mm_func     = head[0].func;
    assign byp.h2c_byp_in_mm_cidx     = head[0].cidx;
    assign byp.h2c_byp_in_mm_port_id  = head[0].port_id;
    assign byp.h2c_byp_in_mm_no_dma   = head[0].no_dma;

    assign byp.h2c_byp_in_st_vld      = ~empty[1];
    assign byp.h2c_byp_in_st_addr     = head[1].addr;
    assign byp.h2c_byp_in_st_len      = head[1].len;
    assign byp.h2c_byp_in_st_sop      = head[1].sop;
    assign byp.h2c_byp_in_st_eop      = head[1].eop;
    assign byp.h2c_byp_in_st_mrkr_req = head[1].mrkr_req;
    assign byp.h2c_byp_in_st_sdi      = head[1].sdi;
    assign byp.h2c_byp_in_st_qid      = head[1].qid;
    assign byp.h2c_byp_in_st_error    = head[1].error;
    assign byp.h2c_byp_in_st_func     = head[1].func;
    assign byp.h2c_byp_in_st_cidx     = head[1].cidx;
    assign byp.h2c_byp_in_st_port_id  = head[1].port_id;
    assign byp.h2c_byp_in_st_no_dma   = head[1].no_dma;

    logic unused_bits;
    assign unused_bits = ^{byp.h2c_byp_out_dsc, byp.h2c_byp_out_dsc_sz,
                           head[0].sop, head[0].eop, head[1].wadr};
endmodule

// File: tb/tb_dsc_byp_h2c_fifo.sv
// Randomized bench for dsc_byp_h2c_fifo: queue-based reference model checked every
// cycle on the falling edge, plus directed scenarios with literal expectations.
module tb_dsc_byp_h2c_fifo;
    localparam int D   = 4;
    localparam int QW  = 11;
    localparam int TMO = 16;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          bypass = 1'b0, mm_req = 1'b0, st_req = 1'b0;
    logic [QW-1:0] mqid = '0;
    logic          mm_rsp, mm_busy, mm_tmo, st_rsp, st_busy, st_tmo;
    logic [CW-1:0] drop_cnt;

    always #5 clk = ~clk;

    dsc_byp_h2c_fifo_if #(.QID_W(QW)) bif ();

    dsc_byp_h2c_fifo #(.FIFO_DEPTH(D), .QID_W(QW), .TMO_CYC(TMO), .CNT_W(CW)) dut (
        .axi_aclk(clk), .axi_aresetn(rst_n), .h2c_dsc_bypass(bypass),
        .h2c_mm_marker_req(mm_req), .h2c_st_marker_req(st_req), .marker_qid(mqid),
        .h2c_mm_marker_rsp(mm_rsp), .h2c_mm_marker_busy(mm_busy), .h2c_mm_marker_tmo(mm_tmo),
        .h2c_st_marker_rsp(st_rsp), .h2c_st_marker_busy(st_busy), .h2c_st_marker_tmo(st_tmo),
        .drop_cnt(drop_cnt), .byp(bif)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [63:0] a;
        logic [63:0] w;
        logic [15:0] len;
        logic        sop, eop, mrkr, sdi;
        logic [QW-1:0] qid;
        logic        err;
        logic [7:0]  func;
        logic [15:0] cidx;
        logic [2:0]  port;
        logic        nodma;
    } ent_t;

    ent_t mq[$];
    ent_t sq[$];
    int   ph[2];
    int   start[2];
    logic e_rsp[2], e_tmo[2];
    int   e_drop;
    int   cyc = 0;

    function automatic ent_t blank();
        ent_t e;
        e = '{a: 0, w: 0, len: 0, sop: 0, eop: 0, mrkr: 0, sdi: 0, qid: 0, err: 0,
              func: 0, cidx: 0, port: 0, nodma: 0};
        return e;
    endfunction

    function automatic ent_t model_dec();
        ent_t e;
        logic [255:0] d;
        e = blank();
        d = bif.h2c_byp_out_dsc;
        if (bif.h2c_byp_out_st_mm) begin
            e.a = d[63:0]; e.w = d[191:128]; e.len = d[79:64]; e.sdi = d[94];
        end else begin
            e.a = d[127:64]; e.len = d[47:32]; e.sop = d[48]; e.eop = d[49]; e.sdi = d[49];
        end
        e.qid = bif.h2c_byp_out_qid; e.err = bif.h2c_byp_out_error; e.func = bif.h2c_byp_out_func;
        e.cidx = bif.h2c_byp_out_cidx; e.port = bif.h2c_byp_out_port_id;
        return e;
    endfunction

    // Reference model and per-cycle compare.
    always @(negedge clk) begin : model
        ent_t mh, sh, mk;
        logic mv, sv, pop0, pop1, is_rsp, exp_rdy, acc, hit;
        logic [1:0] space, pend, rq;
        int tgt;
        if (!rst_n) begin
            chk("rst_rdy", bif.h2c_byp_out_rdy, 0);
            chk("rst_vld", {bif.h2c_byp_in_mm_vld, bif.h2c_byp_in_st_vld}, 0);
            chk("rst_marker", {mm_rsp, mm_busy, mm_tmo, st_rsp, st_busy, st_tmo}, 0);
            chk("rst_drop", drop_cnt, 0);
            mq.delete(); sq.delete();
            for (int p = 0; p < 2; p++) begin
                ph[p] = 0; e_rsp[p] = 0; e_tmo[p] = 0;
            end
            e_drop = 0;
        end else begin
            mv = (mq.size() > 0);
            sv = (sq.size() > 0);
            mh = mv ? mq[0] : blank();
            sh = sv ? sq[0] : blank();
            chk("mm_out",
                {bif.h2c_byp_in_mm_radr, bif.h2c_byp_in_mm_wadr, bif.h2c_byp_in_mm_len,
                 bif.h2c_byp_in_mm_mrkr_req, bif.h2c_byp_in_mm_sdi, bif.h2c_byp_in_mm_qid,
                 bif.h2c_byp_in_mm_error, bif.h2c_byp_in_mm_func, bif.h2c_byp_in_mm_cidx,
                 bif.h2c_byp_in_mm_port_id, bif.h2c_byp_in_mm_no_dma, bif.h2c_byp_in_mm_vld},
                {mh.a, mh.w, mh.len, mh.mrkr, mh.sdi, mh.qid, mh.err, mh.func, mh.cidx,
                 mh.port, mh.nodma, mv});
            chk("st_out",
                {bif.h2c_byp_in_st_addr, bif.h2c_byp_in_st_len, bif.h2c_byp_in_st_eop,
                 bif.h2c_byp_in_st_sop, bif.h2c_byp_in_st_mrkr_req, bif.h2c_byp_in_st_sdi,
                 bif.h2c_byp_in_st_qid, bif.h2c_byp_in_st_error, bif.h2c_byp_in_st_func,
                 bif.h2c_byp_in_st_cidx, bif.h2c_byp_in_st_port_id, bif.h2c_byp_in_st_no_dma,
                 bif.h2c_byp_in_st_vld},
                {sh.a, sh.len, sh.eop, sh.sop, sh.mrkr, sh.sdi, sh.qid, sh.err, sh.func,
                 sh.cidx, sh.port, sh.nodma, sv});
            chk("mm_marker", {mm_rsp, mm_busy, mm_tmo}, {e_rsp[0], ph[0] != 0, e_tmo[0]});
            chk("st_marker", {st_rsp, st_busy, st_tmo}, {e_rsp[1], ph[1] != 0, e_tmo[1]});
            chk("drop_cnt", drop_cnt, e_drop);

            pop0 = mv & bif.h2c_byp_in_mm_rdy;
            pop1 = sv & bif.h2c_byp_in_st_rdy;
            space[0] = (mq.size() < D) || pop0;
            space[1] = (sq.size() < D) || pop1;
            pend[0] = (ph[0] == 1);
            pend[1] = (ph[1] == 1);
            is_rsp = (bif.h2c_byp_out_fmt == 3'b001);
            tgt = bif.h2c_byp_out_st_mm ? 0 : 1;
            if (is_rsp || !bypass) exp_rdy = 1'b1;
            else                   exp_rdy = space[tgt] && !pend[tgt];
            chk("byp_out_rdy", bif.h2c_byp_out_rdy, exp_rdy);
            acc = bif.h2c_byp_out_vld & exp_rdy;

            if (pop0) void'(mq.pop_front());
            if (pop1) void'(sq.pop_front());
            mk = blank(); mk.mrkr = 1; mk.nodma = 1; mk.qid = mqid;
            rq = {st_req, mm_req};
            for (int p = 0; p < 2; p++) begin
                e_rsp[p] = 0; e_tmo[p] = 0;
                hit = acc && is_rsp && (tgt == p);
                if (ph[p] == 0) begin
                    if (rq[p]) ph[p] = 1;
                end else if (ph[p] == 1) begin
                    if (space[p]) begin
                        if (p == 0) mq.push_back(mk); else sq.push_back(mk);
                        ph[p] = 2; start[p] = cyc;
                    end
                end else begin
                    if (hit) begin e_rsp[p] = 1; ph[p] = 0; end
                    else if (cyc - start[p] == TMO) begin e_tmo[p] = 1; ph[p] = 0; end
                end
            end
            if (acc && !is_rsp) begin
                if (!bypass) begin
                    if (e_drop < (1 << CW) - 1) e_drop++;
                end else if (tgt == 0) mq.push_back(model_dec());
                else sq.push_back(model_dec());
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        mm_req = 1'b0;
        st_req = 1'b0;
    endtask

    task automatic rnd_fields();
        bif.h2c_byp_out_qid     = QW'($urandom);
        bif.h2c_byp_out_error   = 1'($urandom);
        bif.h2c_byp_out_func    = 8'($urandom);
        bif.h2c_byp_out_cidx    = 16'($urandom);
        bif.h2c_byp_out_port_id = 3'($urandom);
        bif.h2c_byp_out_dsc_sz  = 2'($urandom);
    endtask

    function automatic logic [255:0] rnd_dsc();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send(input logic [255:0] d, input logic [2:0] fmt, input logic stmm,
                        input int bound, output logic ok);
        bif.h2c_byp_out_dsc   = d;
        bif.h2c_byp_out_fmt   = fmt;
        bif.h2c_byp_out_st_mm = stmm;
        rnd_fields();
        bif.h2c_byp_out_vld   = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            #1;
            if (bif.h2c_byp_out_rdy) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        bif.h2c_byp_out_vld = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [255:0] d;
        logic ok;
        int   cnt;
        bif.h2c_byp_out_vld = 1'b0;
        bif.h2c_byp_out_dsc = '0;
        bif.h2c_byp_out_fmt = '0;
        bif.h2c_byp_out_st_mm = 1'b0;
        rnd_fields();
        bif.h2c_byp_in_mm_rdy = 1'b0;
        bif.h2c_byp_in_st_rdy = 1'b0;
        repeat (3) tick();
        chk("lit_rst_rdy", bif.h2c_byp_out_rdy, 0);
        rst_n = 1'b1;
        tick();

        // 1: four MM descriptors fill the FIFO, fifth stalls, then drain in order
        bypass = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = rnd_dsc();
            d[79:64] = 16'h40;
            d[94] = (i == 3);
            send(d, 3'b000, 1'b1, 5, ok);
            chk("lit_t1_acc", ok, 1);
        end
        send(rnd_dsc(), 3'b000, 1'b1, 4, ok);
        chk("lit_t1_stall", ok, 0);
        chk("lit_t1_len", {bif.h2c_byp_in_mm_vld, bif.h2c_byp_in_mm_len}, {1'b1, 16'h40});
        bif.h2c_byp_in_mm_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("lit_t1_sdi", {bif.h2c_byp_in_mm_vld, bif.h2c_byp_in_mm_sdi}, {1'b1, i == 3});
            tick();
        end
        chk("lit_t1_empty", bif.h2c_byp_in_mm_vld, 0);

        // 2: ST descriptor visible one cycle after acceptance
        d = '0;
        d[48] = 1'b1; d[49] = 1'b1; d[47:32] = 16'h100; d[127:64] = 64'h1000;
        send(d, 3'b000, 1'b0, 5, ok);
        chk("lit_t2_st",
            {bif.h2c_byp_in_st_vld, bif.h2c_byp_in_st_sop, bif.h2c_byp_in_st_eop,
             bif.h2c_byp_in_st_sdi, bif.h2c_byp_in_st_len, bif.h2c_byp_in_st_addr},
            {4'b1111, 16'h100, 64'h1000});
        bif.h2c_byp_in_st_rdy = 1'b1;
        tick();

        // 3: drops counted while bypass is off, saturating at 15
        bypass = 1'b0;
        for (int i = 0; i < 10; i++) send(rnd_dsc(), 3'b000, 1'($urandom), 1, ok);
        chk("lit_t3_drop10", drop_cnt, 10);
        chk("lit_t3_novld", {bif.h2c_byp_in_mm_vld, bif.h2c_byp_in_st_vld}, 0);
        for (int i = 0; i < 10; i++) send(rnd_dsc(), 3'b000, 1'($urandom), 1, ok);
        chk("lit_t3_drop_sat", drop_cnt, 15);

        // 4: MM marker injected and answered before the timeout
        bypass = 1'b1;
        mqid = 11'd5;
        mm_req = 1'b1;
        tick();
        chk("lit_t4_busy_pend", mm_busy, 1);
        tick();
        chk("lit_t4_marker",
            {bif.h2c_byp_in_mm_vld, bif.h2c_byp_in_mm_mrkr_req, bif.h2c_byp_in_mm_no_dma,
             bif.h2c_byp_in_mm_qid}, {3'b111, 11'd5});
        repeat (8) tick();
        chk("lit_t4_busy_wait", mm_busy, 1);
        send(rnd_dsc(), 3'b001, 1'b1, 2, ok);
        chk("lit_t4_rsp", {mm_rsp, mm_busy, mm_tmo}, 3'b100);
        tick();
        chk("lit_t4_rsp_end", mm_rsp, 0);

        // 5: ST marker with no response times out TMO cycles after it appears
        st_req = 1'b1;
        tick();
        tick();
        chk("lit_t5_marker", {bif.h2c_byp_in_st_vld, bif.h2c_byp_in_st_mrkr_req}, 2'b11);
        cnt = 0;
        while (!st_tmo && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("lit_t5_tmo_cycles", cnt, TMO);
        chk("lit_t5_busy", st_busy, 0);
        tick();
        chk("lit_t5_tmo_end", st_tmo, 0);

        // 6: async reset with entries queued and a marker waiting
        bif.h2c_byp_in_mm_rdy = 1'b0;
        bif.h2c_byp_in_st_rdy = 1'b0;
        for (int i = 0; i < 3; i++) send(rnd_dsc(), 3'b000, 1'b1, 3, ok);
        send(rnd_dsc(), 3'b000, 1'b0, 3, ok);
        mm_req = 1'b1;
        tick();
        tick();
        chk("lit_t6_busy", mm_busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("lit_t6_rst",
            {bif.h2c_byp_in_mm_vld, bif.h2c_byp_in_st_vld, mm_busy, st_busy, drop_cnt}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("lit_t6_empty", {bif.h2c_byp_in_mm_vld, bif.h2c_byp_in_st_vld}, 0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) bypass = ($urandom_range(0, 4) != 0);
            bif.h2c_byp_out_vld   = 1'($urandom);
            bif.h2c_byp_out_dsc   = rnd_dsc();
            bif.h2c_byp_out_fmt   = ($urandom_range(0, 5) == 0) ? 3'b001 : 3'($urandom);
            bif.h2c_byp_out_st_mm = 1'($urandom);
            rnd_fields();
            bif.h2c_byp_in_mm_rdy = ($urandom_range(0, 3) != 0);
            bif.h2c_byp_in_st_rdy = ($urandom_range(0, 3) != 0);
            mm_req = ($urandom_range(0, 30) == 0);
            st_req = ($urandom_range(0, 30) == 0);
            mqid   = QW'($urandom);
            rst_n  = !(i >= 1500 && i < 1502);
            @(posedge clk);
            #1;
        end
        bif.h2c_byp_out_vld = 1'b0;
        mm_req = 1'b0;
        st_req = 1'b0;
        repeat (5) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
